// File: rtl/connect4_move_input_pkg.sv
// Shared types and helpers for the Connect-4 move input stage.
package connect4_pkg;

    localparam int NUM_COLS = 7;
    localparam int COL_W    = 3;

    typedef logic [COL_W-1:0] col_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_REL = 2'd2
    } move_state_t;

    // A column is playable when it exists on the board and is not yet full.
    function automatic logic col_legal(input col_t col, input logic [NUM_COLS-1:0] full);
        logic [2**COL_W-1:0] full_ext;
        full_ext = {{(2**COL_W-NUM_COLS){1'b0}}, full};
        return ({1'b0, col} < (COL_W+1)'(NUM_COLS)) && !full_ext[col];
    endfunction

endpackage

// File: rtl/connect4_move_input_key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stable-count debouncer, press pulse
// and a "known released" flag that ignores the reset-filled synchroniser contents.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic released
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r, sync2_r, level_r, press_r, released_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       settle_r;
    logic             level_next_s, press_next_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Stable-count debounce: level follows the synced key after a full run of mismatches.
    always_comb begin
        level_next_s = level_r;
        press_next_s = 1'b0;
        cnt_next_s   = '0;
        if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_next_s = sync2_r;
                press_next_s = ~sync2_r;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = '0;
        end
    end

    // Synchroniser, debounce state and settle tracker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            level_r    <= 1'b1;
            press_r    <= 1'b0;
            cnt_r      <= '0;
            settle_r   <= 2'b00;
            released_r <= 1'b0;
        end else begin
            sync1_r    <= key_n;
            sync2_r    <= sync1_r;
            level_r    <= level_next_s;
            press_r    <= press_next_s;
            cnt_r      <= cnt_next_s;
            settle_r   <= {settle_r[0], 1'b1};
            released_r <= settle_r[1] & sync2_r & level_r;
        end
    end

    assign level    = level_r;
    assign press    = press_r;
    assign released = released_r;

endmodule

// File: rtl/connect4_move_input.sv
// Connect-4 move input stage: debounced drop key + column switches -> valid/ready move.
// Optional cancel key enabled by defining CONNECT4_MOVE_CANCEL_EN.
module connect4_move_input
    import connect4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                key_drop_n,
    input  logic                key_cancel_n,
    input  logic [COL_W-1:0]    sw_col,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                move_ready,
    output logic                move_valid,
    output logic [COL_W-1:0]    move_col,
    output logic                move_err,
    output logic                busy
);

    move_state_t state_r, state_next_s;
    col_t        sw_sync1_r, sw_sync2_r, move_col_r, col_next_s;
    logic        move_valid_r, move_err_r, busy_r, armed_r;
    logic        valid_next_s, err_next_s;
    logic        drop_level_s, drop_press_s, drop_released_s, cancel_press_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_drop (
        .clk      (CLOCK_50),
        .rst      (reset),
        .key_n    (key_drop_n),
        .level    (drop_level_s),
        .press    (drop_press_s),
        .released (drop_released_s)
    );

`ifdef CONNECT4_MOVE_CANCEL_EN
    logic cancel_level_s, cancel_raw_s, cancel_released_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .clk      (CLOCK_50),
        .rst      (reset),
        .key_n    (key_cancel_n),
        .level    (cancel_level_s),
        .press    (cancel_raw_s),
        .released (cancel_released_s)
    );

    assign cancel_press_s = cancel_raw_s & ~cancel_level_s & (cancel_released_s | 1'b1);
`else
    assign cancel_press_s = 1'b0 & ~key_cancel_n;
`endif

    // Move FSM: one offer per accepted press; presses are ignored until the key
    // has been seen released since reset, so a key held through reset cannot fire.
    always_comb begin
        state_next_s = state_r;
        valid_next_s = 1'b0;
        err_next_s   = 1'b0;
        col_next_s   = move_col_r;
        case (state_r)
            IDLE: begin
                if (drop_press_s && armed_r) begin
                    if (col_legal(sw_sync2_r, col_full)) begin
                        valid_next_s = 1'b1;
                        col_next_s   = sw_sync2_r;
                        state_next_s = OFFER;
                    end else begin
                        err_next_s   = 1'b1;
                        state_next_s = WAIT_REL;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            OFFER: begin
                if (move_ready) begin
                    state_next_s = WAIT_REL;
                end else if (cancel_press_s) begin
                    state_next_s = WAIT_REL;
                end else begin
                    valid_next_s = 1'b1;
                end
            end
            WAIT_REL: begin
                if (drop_level_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_REL;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, registered outputs and switch synchroniser.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            move_valid_r <= 1'b0;
            move_col_r   <= '0;
            move_err_r   <= 1'b0;
            busy_r       <= 1'b0;
            armed_r      <= 1'b0;
            sw_sync1_r   <= '1;
            sw_sync2_r   <= '1;
        end else begin
            state_r      <= state_next_s;
            move_valid_r <= valid_next_s;
            move_col_r   <= col_next_s;
            move_err_r   <= err_next_s;
            busy_r       <= (state_next_s != IDLE);
            armed_r      <= armed_r | drop_released_s;
            sw_sync1_r   <= sw_col;
            sw_sync2_r   <= sw_sync1_r;
        end
    end

    assign move_valid = move_valid_r;
    assign move_col   = move_col_r;
    assign move_err   = move_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_connect4_move_input.sv
// Directed bench for connect4_move_input with a short debounce window.
module tb_connect4_move_input;

    logic       CLOCK_50, reset, key_drop_n, key_cancel_n, move_ready;
    logic [2:0] sw_col;
    logic [6:0] col_full;
    logic       move_valid, move_err, busy;
    logic [2:0] move_col;

    int total = 0;
    int bad   = 0;
    int xfer_cnt = 0, valid_cyc = 0, err_cyc = 0;
    int n, x0, v0, e0;

    connect4_move_input #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .key_drop_n   (key_drop_n),
        .key_cancel_n (key_cancel_n),
        .sw_col       (sw_col),
        .col_full     (col_full),
        .move_ready   (move_ready),
        .move_valid   (move_valid),
        .move_col     (move_col),
        .move_err     (move_err),
        .busy         (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (move_valid && move_ready) xfer_cnt++;
        if (move_valid) valid_cyc++;
        if (move_err) err_cyc++;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // which: 0 valid high, 1 err high, 2 valid low, 3 busy low
    task automatic wait_for(input int which, output int cycles);
        cycles = 0;
        while (cycles < 30 &&
               !((which == 0 && move_valid) || (which == 1 && move_err) ||
                 (which == 2 && !move_valid) || (which == 3 && !busy))) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1; key_drop_n = 1'b1; key_cancel_n = 1'b1;
        sw_col = 3'd0; col_full = 7'd0; move_ready = 1'b0;
        #1;
        check("rst_valid", {31'd0, move_valid}, 32'd0);
        check("rst_col", {29'd0, move_col}, 32'd0);
        check("rst_err", {31'd0, move_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        // clean press, held long
        sw_col = 3'd3; move_ready = 1'b1; x0 = xfer_cnt;
        repeat (3) tick();
        key_drop_n = 1'b0;
        wait_for(0, n);
        check("clean_latency", n, 32'd7);
        check("clean_col", {29'd0, move_col}, 32'd3);
        tick();
        check("clean_valid_drop", {31'd0, move_valid}, 32'd0);
        check("clean_busy", {31'd0, busy}, 32'd1);
        repeat (50) tick();
        check("clean_one_xfer", xfer_cnt - x0, 32'd1);
        check("clean_no_err", err_cyc, 32'd0);
        key_drop_n = 1'b1;
        wait_for(3, n);
        check("clean_idle", {31'd0, busy}, 32'd0);
        repeat (3) tick();

        // bouncy press
        sw_col = 3'd4; x0 = xfer_cnt; v0 = valid_cyc;
        for (int i = 0; i < 10; i++) begin
            key_drop_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) tick();
        end
        check("bounce_quiet", valid_cyc - v0, 32'd0);
        key_drop_n = 1'b0;
        wait_for(0, n);
        check("bounce_latency", n, 32'd7);
        check("bounce_col", {29'd0, move_col}, 32'd4);
        repeat (20) tick();
        check("bounce_one_xfer", xfer_cnt - x0, 32'd1);
        key_drop_n = 1'b1;
        wait_for(3, n);
        repeat (3) tick();

        // illegal column index
        sw_col = 3'd7; e0 = err_cyc; v0 = valid_cyc;
        repeat (3) tick();
        key_drop_n = 1'b0;
        wait_for(1, n);
        check("ill_err_latency", n, 32'd7);
        check("ill_no_valid", {31'd0, move_valid}, 32'd0);
        tick();
        check("ill_err_pulse", {31'd0, move_err}, 32'd0);
        repeat (10) tick();
        check("ill_busy_held", {31'd0, busy}, 32'd1);
        check("ill_err_once", err_cyc - e0, 32'd1);
        check("ill_valid_never", valid_cyc - v0, 32'd0);
        key_drop_n = 1'b1;
        wait_for(3, n);
        check("ill_idle", {31'd0, busy}, 32'd0);
        repeat (3) tick();

        // full column
        sw_col = 3'd2; col_full = 7'b0000100; e0 = err_cyc; v0 = valid_cyc;
        repeat (3) tick();
        key_drop_n = 1'b0;
        wait_for(1, n);
        check("full_err_latency", n, 32'd7);
        repeat (10) tick();
        check("full_err_once", err_cyc - e0, 32'd1);
        check("full_valid_never", valid_cyc - v0, 32'd0);
        check("full_busy_held", {31'd0, busy}, 32'd1);
        key_drop_n = 1'b1;
        wait_for(3, n);
        col_full = 7'd0;
        repeat (3) tick();

        // backpressure
        sw_col = 3'd5; move_ready = 1'b0;
        repeat (3) tick();
        key_drop_n = 1'b0;
        wait_for(0, n);
        check("bp_latency", n, 32'd7);
        x0 = xfer_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {28'd0, move_valid, move_col}, {28'd0, 1'b1, 3'd5});
        end
        move_ready = 1'b1;
        tick();
        check("bp_valid_drop", {31'd0, move_valid}, 32'd0);
        check("bp_one_xfer", xfer_cnt - x0, 32'd1);
        key_drop_n = 1'b1; move_ready = 1'b0;
        wait_for(3, n);
        repeat (3) tick();

        // async reset while offering, key held through reset
        sw_col = 3'd1;
        key_drop_n = 1'b0;
        wait_for(0, n);
        check("rstoff_offer", {31'd0, move_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstoff_outputs", {26'd0, move_valid, move_col, move_err, busy}, 32'd0);
        repeat (2) tick();
        reset = 1'b0; v0 = valid_cyc; e0 = err_cyc;
        repeat (20) tick();
        check("rstoff_no_move", valid_cyc - v0, 32'd0);
        check("rstoff_no_err", err_cyc - e0, 32'd0);
        check("rstoff_not_busy", {31'd0, busy}, 32'd0);
        key_drop_n = 1'b1;
        repeat (15) tick();
        key_drop_n = 1'b0;
        wait_for(0, n);
        check("rstoff_repress", n, 32'd7);
        check("rstoff_col", {29'd0, move_col}, 32'd1);
        move_ready = 1'b1;
        tick();
        check("rstoff_drop", {31'd0, move_valid}, 32'd0);
        key_drop_n = 1'b1; move_ready = 1'b0;
        wait_for(3, n);
        repeat (3) tick();

`ifdef CONNECT4_MOVE_CANCEL_EN
        // cancel during offer
        sw_col = 3'd6;
        key_drop_n = 1'b0;
        wait_for(0, n);
        x0 = xfer_cnt;
        key_cancel_n = 1'b0;
        wait_for(2, n);
        check("cancel_latency", n, 32'd7);
        check("cancel_no_xfer", xfer_cnt - x0, 32'd0);
        key_cancel_n = 1'b1; key_drop_n = 1'b1;
        wait_for(3, n);
        repeat (10) tick();

        // cancel and ready together: transfer wins
        key_drop_n = 1'b0;
        wait_for(0, n);
        x0 = xfer_cnt;
        key_cancel_n = 1'b0;
        repeat (6) tick();
        move_ready = 1'b1;
        tick();
        check("cancel_ready_drop", {31'd0, move_valid}, 32'd0);
        check("cancel_ready_xfer", xfer_cnt - x0, 32'd1);
        key_cancel_n = 1'b1; key_drop_n = 1'b1; move_ready = 1'b0;
        wait_for(3, n);
        repeat (3) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
